// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider ratio change controller.
// Holds the FSM encoding, ratio limits and timer width.
package div_ctrl_pkg;

  localparam int NUM_W   = 4;
  localparam int TIMER_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_LOAD = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [NUM_W-1:0]   NUM_DEFAULT_C = 4'd8;
  localparam logic [NUM_W-1:0]   NUM_MIN_C     = 4'd6;
  localparam logic [NUM_W-1:0]   NUM_MAX_C     = 4'd15;
  localparam logic [TIMER_W-1:0] TIMEOUT_C     = 5'd31;

  function automatic logic num_legal(input logic [NUM_W-1:0] n,
                                     input logic [NUM_W-1:0] lo,
                                     input logic [NUM_W-1:0] hi);
    return (n >= lo) && (n <= hi);
  endfunction

endpackage

// File: rtl/div_ratio_ctrl_if.sv
// Request/ack bundle between the two requesters, the clock divider and the controller.
// The master side drives requests and div_enable; the slave side is the controller.
interface div_ratio_ctrl_if;
  import div_ctrl_pkg::*;

  logic             req0;
  logic [NUM_W-1:0] num0;
  logic             req1;
  logic [NUM_W-1:0] num1;
  logic             div_enable;
  logic [NUM_W-1:0] num_out;
  logic             ack0;
  logic             ack1;
  logic             resp_err;
  logic             busy;

  modport master (
    output req0, num0, req1, num1, div_enable,
    input  num_out, ack0, ack1, resp_err, busy
  );

  modport slave (
    input  req0, num0, req1, num1, div_enable,
    output num_out, ack0, ack1, resp_err, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; purely combinational.
// A lone request always wins; on contention the requester not served last wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt0,
  output logic gnt1
);

  // last_grant: 0 = requester 0 served last, 1 = requester 1 served last
  assign gnt0 = req0 & (~req1 | last_grant);
  assign gnt1 = req1 & (~req0 | ~last_grant);

endmodule

// File: rtl/div_ratio_ctrl.sv
// Arbitrates ratio change requests and applies them to the divider Num input
// on a frame boundary, restoring the old ratio if the divider never signals one.
//
// state | meaning
// IDLE  | waiting for a request; requests sampled only here
// SYNC  | new ratio driven, waiting for div_enable or timeout
// LOAD  | one cycle holding num_out while the divider samples it
// RESP  | one-cycle ack to the granted requester with resp_err
module div_ratio_ctrl
  import div_ctrl_pkg::*;
#(
  parameter logic [NUM_W-1:0]   NUM_DEFAULT = NUM_DEFAULT_C,
  parameter logic [NUM_W-1:0]   NUM_MIN     = NUM_MIN_C,
  parameter logic [NUM_W-1:0]   NUM_MAX     = NUM_MAX_C,
  parameter logic [TIMER_W-1:0] TIMEOUT     = TIMEOUT_C
) (
  input  logic           clk_high,
  input  logic           rst,
  div_ratio_ctrl_if.slave bus
);

  state_e             state_q, state_d;
  logic [NUM_W-1:0]   num_out_q, num_out_d;
  logic [NUM_W-1:0]   num_prev_q, num_prev_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               last_grant_q, last_grant_d;
  logic               gnt_id_q, gnt_id_d;
  logic               err_q, err_d;

  logic             gnt0, gnt1;
  logic [NUM_W-1:0] num_sel;

  rr_arb2 u_arb (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .last_grant (last_grant_q),
    .gnt0       (gnt0),
    .gnt1       (gnt1)
  );

  assign num_sel = gnt1 ? bus.num1 : bus.num0;

  always_ff @(posedge clk_high or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      num_out_q    <= NUM_DEFAULT;
      num_prev_q   <= NUM_DEFAULT;
      timer_q      <= '0;
      last_grant_q <= 1'b1;
      gnt_id_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_out_q    <= num_out_d;
      num_prev_q   <= num_prev_d;
      timer_q      <= timer_d;
      last_grant_q <= last_grant_d;
      gnt_id_q     <= gnt_id_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    num_out_d    = num_out_q;
    num_prev_d   = num_prev_q;
    timer_d      = timer_q;
    last_grant_d = last_grant_q;
    gnt_id_d     = gnt_id_q;
    err_d        = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt0 || gnt1) begin
          last_grant_d = gnt1;
          gnt_id_d     = gnt1;
          if (!num_legal(num_sel, NUM_MIN, NUM_MAX)) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (num_sel == num_out_q) begin
            err_d   = 1'b0;
            state_d = ST_RESP;
          end else begin
            num_prev_d = num_out_q;
            num_out_d  = num_sel;
            timer_d    = '0;
            state_d    = ST_SYNC;
          end
        end
      end
      ST_SYNC: begin
        // A frame end on the timeout edge still counts as success.
        if (bus.div_enable) begin
          state_d = ST_LOAD;
        end else begin
          timer_d = timer_q + 1'b1;
          if (timer_q == TIMEOUT - 1'b1) begin
            num_out_d = num_prev_q;
            err_d     = 1'b1;
            state_d   = ST_RESP;
          end
        end
      end
      ST_LOAD: begin
        err_d   = 1'b0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.num_out  = num_out_q;
  assign bus.ack0     = (state_q == ST_RESP) && !gnt_id_q;
  assign bus.ack1     = (state_q == ST_RESP) && gnt_id_q;
  assign bus.resp_err = (state_q == ST_RESP) && err_q;
  assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Directed self-checking bench for div_ratio_ctrl.
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_div_ratio_ctrl;

  logic clk_high = 1'b0;
  logic rst      = 1'b1;
  int   n_vec    = 0;
  int   n_err    = 0;

  div_ratio_ctrl_if bus ();

  div_ratio_ctrl dut (
    .clk_high (clk_high),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk_high = ~clk_high;

  // Acks must be mutually exclusive and resp_err only qualifies an ack.
  always @(negedge clk_high) begin
    if (!rst) begin
      n_vec++;
      if ({bus.ack0 & bus.ack1, bus.resp_err & ~bus.ack0 & ~bus.ack1} !== 2'b00) begin
        n_err++;
        $display("FAIL ack_excl: ack0=%0b ack1=%0b resp_err=%0b required no overlap and no bare err",
                 bus.ack0, bus.ack1, bus.resp_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk_high);
    #1;
  endtask

  // {ack0, ack1, resp_err, busy}
  task automatic test_reset();
    bus.req0 = 0; bus.num0 = 0; bus.req1 = 0; bus.num1 = 0; bus.div_enable = 0;
    rst = 1;
    tick(); tick();
    n_vec++;
    if ({bus.ack0, bus.ack1, bus.resp_err, bus.busy, bus.num_out} !== {4'b0000, 4'd8}) begin
      n_err++;
      $display("FAIL reset_state: got flags=%b num_out=%0d required flags=0000 num_out=8",
               {bus.ack0, bus.ack1, bus.resp_err, bus.busy}, bus.num_out);
    end
    rst = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_vec++;
      if ({bus.ack0, bus.ack1, bus.resp_err, bus.busy, bus.num_out} !== {4'b0000, 4'd8}) begin
        n_err++;
        $display("FAIL idle_after_reset cyc %0d: flags=%b num_out=%0d required 0000/8", i,
                 {bus.ack0, bus.ack1, bus.resp_err, bus.busy}, bus.num_out);
      end
    end
  endtask

  task automatic test_ignore_enable_idle();
    bus.div_enable = 1;
    tick();
    bus.div_enable = 0;
    n_vec++;
    if ({bus.busy, bus.num_out} !== {1'b0, 4'd8}) begin
      n_err++;
      $display("FAIL enable_in_idle: busy=%0b num_out=%0d required 0/8", bus.busy, bus.num_out);
    end
  endtask

  task automatic test_apply();
    bus.req0 = 1; bus.num0 = 4'd10;
    tick();
    n_vec++;
    if ({bus.ack0, bus.ack1, bus.resp_err, bus.busy, bus.num_out} !== {4'b0001, 4'd10}) begin
      n_err++;
      $display("FAIL apply_grant: flags=%b num_out=%0d required 0001/10",
               {bus.ack0, bus.ack1, bus.resp_err, bus.busy}, bus.num_out);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if ({bus.ack0, bus.busy, bus.num_out} !== {2'b01, 4'd10}) begin
        n_err++;
        $display("FAIL apply_sync cyc %0d: ack0=%0b busy=%0b num_out=%0d required 0/1/10", i,
                 bus.ack0, bus.busy, bus.num_out);
      end
    end
    bus.div_enable = 1;
    tick();
    bus.div_enable = 0;
    n_vec++;
    if ({bus.ack0, bus.busy, bus.num_out} !== {2'b01, 4'd10}) begin
      n_err++;
      $display("FAIL apply_load: ack0=%0b busy=%0b num_out=%0d required 0/1/10",
               bus.ack0, bus.busy, bus.num_out);
    end
    tick();
    n_vec++;
    if ({bus.ack0, bus.ack1, bus.resp_err, bus.num_out} !== {3'b100, 4'd10}) begin
      n_err++;
      $display("FAIL apply_ack: ack0/ack1/err=%b num_out=%0d required 100/10",
               {bus.ack0, bus.ack1, bus.resp_err}, bus.num_out);
    end
    bus.req0 = 0;
    tick();
    n_vec++;
    if ({bus.ack0, bus.busy, bus.num_out} !== {2'b00, 4'd10}) begin
      n_err++;
      $display("FAIL apply_done: ack0=%0b busy=%0b num_out=%0d required 0/0/10",
               bus.ack0, bus.busy, bus.num_out);
    end
  endtask

  task automatic test_reject(input logic [3:0] bad);
    bus.req1 = 1; bus.num1 = bad;
    tick();
    n_vec++;
    if ({bus.ack0, bus.ack1, bus.resp_err, bus.num_out} !== {3'b011, 4'd10}) begin
      n_err++;
      $display("FAIL reject num=%0d: ack0/ack1/err=%b num_out=%0d required 011/10", bad,
               {bus.ack0, bus.ack1, bus.resp_err}, bus.num_out);
    end
    bus.req1 = 0;
    tick();
    n_vec++;
    if ({bus.ack1, bus.busy, bus.num_out} !== {2'b00, 4'd10}) begin
      n_err++;
      $display("FAIL reject_done num=%0d: ack1=%0b busy=%0b num_out=%0d required 0/0/10", bad,
               bus.ack1, bus.busy, bus.num_out);
    end
  endtask

  // Both requesters ask for the current ratio; the expected winner goes first.
  task automatic test_contention(input logic first_is_1);
    bus.req0 = 1; bus.num0 = 4'd10;
    bus.req1 = 1; bus.num1 = 4'd10;
    tick();
    n_vec++;
    if ({bus.ack0, bus.ack1, bus.resp_err} !== {~first_is_1, first_is_1, 1'b0}) begin
      n_err++;
      $display("FAIL contention_first: ack0/ack1/err=%b required %b",
               {bus.ack0, bus.ack1, bus.resp_err}, {~first_is_1, first_is_1, 1'b0});
    end
    if (first_is_1) bus.req1 = 0; else bus.req0 = 0;
    tick();
    n_vec++;
    if ({bus.ack0, bus.ack1, bus.busy} !== 3'b000) begin
      n_err++;
      $display("FAIL contention_gap: ack0/ack1/busy=%b required 000", {bus.ack0, bus.ack1, bus.busy});
    end
    tick();
    n_vec++;
    if ({bus.ack0, bus.ack1, bus.resp_err} !== {first_is_1, ~first_is_1, 1'b0}) begin
      n_err++;
      $display("FAIL contention_second: ack0/ack1/err=%b required %b",
               {bus.ack0, bus.ack1, bus.resp_err}, {first_is_1, ~first_is_1, 1'b0});
    end
    bus.req0 = 0; bus.req1 = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    test_contention(1'b0);
    test_contention(1'b0);
    // A lone requester-0 grant hands the next contention to requester 1.
    bus.req0 = 1; bus.num0 = 4'd10;
    tick();
    bus.req0 = 0;
    tick();
    test_contention(1'b1);
  endtask

  task automatic test_timeout();
    bus.req0 = 1; bus.num0 = 4'd12;
    tick();
    for (int k = 1; k <= 30; k++) begin
      tick();
      n_vec++;
      if ({bus.ack0, bus.busy, bus.num_out} !== {2'b01, 4'd12}) begin
        n_err++;
        $display("FAIL timeout_wait edge %0d: ack0=%0b busy=%0b num_out=%0d required 0/1/12", k,
                 bus.ack0, bus.busy, bus.num_out);
      end
    end
    tick();
    n_vec++;
    if ({bus.ack0, bus.ack1, bus.resp_err, bus.num_out} !== {3'b101, 4'd10}) begin
      n_err++;
      $display("FAIL timeout_abort: ack0/ack1/err=%b num_out=%0d required 101/10",
               {bus.ack0, bus.ack1, bus.resp_err}, bus.num_out);
    end
    bus.req0 = 0;
    tick();
  endtask

  task automatic test_enable_at_timeout();
    bus.req0 = 1; bus.num0 = 4'd13;
    tick();
    for (int k = 1; k <= 30; k++) tick();
    bus.div_enable = 1;
    tick();
    bus.div_enable = 0;
    n_vec++;
    if ({bus.ack0, bus.busy, bus.num_out} !== {2'b01, 4'd13}) begin
      n_err++;
      $display("FAIL edge_win_load: ack0=%0b busy=%0b num_out=%0d required 0/1/13",
               bus.ack0, bus.busy, bus.num_out);
    end
    tick();
    n_vec++;
    if ({bus.ack0, bus.resp_err, bus.num_out} !== {2'b10, 4'd13}) begin
      n_err++;
      $display("FAIL edge_win_ack: ack0=%0b err=%0b num_out=%0d required 1/0/13",
               bus.ack0, bus.resp_err, bus.num_out);
    end
    bus.req0 = 0;
    tick();
  endtask

  task automatic test_reset_in_sync();
    bus.req0 = 1; bus.num0 = 4'd9;
    tick();
    tick();
    rst = 1;
    #1;
    n_vec++;
    if ({bus.ack0, bus.busy, bus.num_out} !== {2'b00, 4'd8}) begin
      n_err++;
      $display("FAIL reset_in_sync: ack0=%0b busy=%0b num_out=%0d required 0/0/8",
               bus.ack0, bus.busy, bus.num_out);
    end
    bus.req0 = 0;
    tick(); tick();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({bus.ack0, bus.ack1, bus.busy, bus.num_out} !== {3'b000, 4'd8}) begin
        n_err++;
        $display("FAIL after_reset cyc %0d: ack0/ack1/busy=%b num_out=%0d required 000/8", i,
                 {bus.ack0, bus.ack1, bus.busy}, bus.num_out);
      end
    end
    bus.req0 = 1; bus.num0 = 4'd9;
    tick();
    bus.div_enable = 1;
    tick();
    bus.div_enable = 0;
    tick();
    n_vec++;
    if ({bus.ack0, bus.resp_err, bus.num_out} !== {2'b10, 4'd9}) begin
      n_err++;
      $display("FAIL rerequest: ack0=%0b err=%0b num_out=%0d required 1/0/9",
               bus.ack0, bus.resp_err, bus.num_out);
    end
    bus.req0 = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_ignore_enable_idle();
    test_apply();
    test_reject(4'd3);
    test_reject(4'd0);
    test_back_to_back();
    test_timeout();
    test_enable_at_timeout();
    test_reset_in_sync();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
